bcd_to_binary_seq: RTL and testbench

//   Sequential BCD-to-binary converter; inverse of the board's binary->BCD display path.

---
 rtl/bcd_to_binary_seq.sv | 147 ++++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq
//   Sequential BCD-to-binary converter, the inverse of the board's binary->BCD
//   display path. A packed group of BCD digits is folded into an unsigned binary
//   value with multiply-by-10-and-add, one digit per clock, most significant
//   digit first.
//
// Parameters
//   DIGITS  number of BCD digits in bcd_in (>= 1)
//   BIN_W   width of bin_out; must satisfy 2**BIN_W > 10**DIGITS - 1
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous reset, active-high, overrides every other input
//   start    conversion request, only looked at while busy is low
//   bcd_in   packed BCD, top nibble = most significant digit, [3:0] = units
//   busy     conversion in progress
//   done     one-cycle pulse when bin_out/err have just been updated
//   err      last request contained a nibble greater than 9
//   bin_out  binary result, held until the next done pulse

module bcd_to_binary_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t             state, state_n;
    logic [BIN_W-1:0]   acc, acc_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [BCD_W-1:0]   shreg, shreg_n;
    logic               busy_n;
    logic               done_n;
    logic               err_n;
    logic [BIN_W-1:0]   bin_n;

    logic [3:0]         digit;
    logic [BIN_W-1:0]   mac;
    logic               bad_digit;

    // The latched digits are shifted left each step, so the digit being
    // folded in is always the top nibble of the shift register.
    assign digit = shreg[BCD_W-1 -: 4];

    // acc*10 built from two shifts; BIN_W is sized so this cannot overflow.
    assign mac = (acc << 3) + (acc << 1) + BIN_W'(digit);

    // Any nibble above 9 makes the whole request invalid.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // State and datapath registers; reset returns everything to idle zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            idx     <= '0;
            shreg   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            bin_out <= '0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            busy    <= busy_n;
            done    <= done_n;
            err     <= err_n;
            bin_out <= bin_n;
        end
    end

    // Next-state and next-output logic. done defaults low so it can only
    // ever be a single-cycle pulse; err and bin_out default to holding.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        idx_n   = idx;
        shreg_n = shreg;
        busy_n  = busy;
        done_n  = 1'b0;
        err_n   = err;
        bin_n   = bin_out;

        case (state)
            IDLE: begin
                if (start) begin
                    if (bad_digit) begin
                        // Invalid request is answered immediately without
                        // entering CONV.
                        bin_n  = '0;
                        err_n  = 1'b1;
                        done_n = 1'b1;
                    end else begin
                        shreg_n = bcd_in;
                        acc_n   = '0;
                        idx_n   = IDX_W'(DIGITS - 1);
                        err_n   = 1'b0;
                        busy_n  = 1'b1;
                        state_n = CONV;
                    end
                end
            end

            CONV: begin
                acc_n   = mac;
                shreg_n = shreg << 4;
                idx_n   = idx - 1'b1;
                if (idx == '0) begin
                    // Units digit folded in: publish the result.
                    bin_n   = mac;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb_bcd_to_binary_seq
//   Directed bench for bcd_to_binary_seq. A 4-digit instance carries most of
//   the scenarios and a 3-digit instance covers the narrow build. Inputs are
//   driven and outputs sampled on the falling edge of clk.

module tb_bcd_to_binary_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [13:0] bin_out;

    logic        start3;
    logic [11:0] bcd_in3;
    logic        busy3;
    logic        done3;
    logic        err3;
    logic [9:0]  bin_out3;

    int pass_cnt;
    int total_cnt;

    bcd_to_binary_seq #(.DIGITS(4), .BIN_W(14)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bin_out (bin_out)
    );

    bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) dut3 (
        .clk     (clk),
        .rst     (rst),
        .start   (start3),
        .bcd_in  (bcd_in3),
        .busy    (busy3),
        .done    (done3),
        .err     (err3),
        .bin_out (bin_out3)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issue one request on the 4-digit instance and wait (bounded) for done.
    // lat counts falling edges from the accept edge to the first one with done.
    task automatic run_conv(input logic [15:0] bcd, output int lat,
                            output logic [13:0] res, output logic e,
                            output logic busy_first);
        @(negedge clk);
        start  = 1'b1;
        bcd_in = bcd;
        @(negedge clk);
        start      = 1'b0;
        busy_first = busy;
        lat        = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = bin_out;
        e   = err;
    endtask

    task automatic test_reset();
        start   = 1'b0;
        bcd_in  = '0;
        start3  = 1'b0;
        bcd_in3 = '0;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", done);
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b0) $display("[TB] FAIL reset_err got %b want 0", err);
        else pass_cnt++;
        total_cnt++;
        if (bin_out !== 14'd0) $display("[TB] FAIL reset_bin got %0d want 0", bin_out);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat; logic [13:0] res; logic e; logic b;
        run_conv(16'h1234, lat, res, e, b);
        total_cnt++;
        if (b !== 1'b1) $display("[TB] FAIL basic_busy got %b want 1", b);
        else pass_cnt++;
        total_cnt++;
        if (lat != 5) $display("[TB] FAIL basic_latency got %0d want 5", lat);
        else pass_cnt++;
        total_cnt++;
        if (res !== 14'd1234) $display("[TB] FAIL basic_bin got %0d want 1234", res);
        else pass_cnt++;
        total_cnt++;
        if (e !== 1'b0) $display("[TB] FAIL basic_err got %b want 0", e);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0) $display("[TB] FAIL basic_done_pulse got %b want 0", done);
        else pass_cnt++;
    endtask

    task automatic test_extremes();
        int lat; logic [13:0] res; logic e; logic b;
        run_conv(16'h9999, lat, res, e, b);
        total_cnt++;
        if (res !== 14'h270F || e !== 1'b0 || lat != 5)
            $display("[TB] FAIL max_9999 got bin=%0d err=%b lat=%0d want 9999/0/5", res, e, lat);
        else pass_cnt++;
        run_conv(16'h0000, lat, res, e, b);
        total_cnt++;
        if (res !== 14'd0 || e !== 1'b0 || lat != 5)
            $display("[TB] FAIL zero got bin=%0d err=%b lat=%0d want 0/0/5", res, e, lat);
        else pass_cnt++;
    endtask

    task automatic test_error();
        int lat; logic [13:0] res; logic e; logic b;
        run_conv(16'h12A4, lat, res, e, b);
        total_cnt++;
        if (lat != 1) $display("[TB] FAIL err_latency got %0d want 1", lat);
        else pass_cnt++;
        total_cnt++;
        if (e !== 1'b1) $display("[TB] FAIL err_flag got %b want 1", e);
        else pass_cnt++;
        total_cnt++;
        if (res !== 14'd0) $display("[TB] FAIL err_bin got %0d want 0", res);
        else pass_cnt++;
        total_cnt++;
        if (b !== 1'b0) $display("[TB] FAIL err_busy got %b want 0", b);
        else pass_cnt++;
        run_conv(16'h0007, lat, res, e, b);
        total_cnt++;
        if (res !== 14'd7 || e !== 1'b0 || lat != 5)
            $display("[TB] FAIL err_recover got bin=%0d err=%b lat=%0d want 7/0/5", res, e, lat);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic want_done;
        // start held high: requests accepted every 5 cycles, bcd_in changes
        // during CONV must not leak into the result.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h0042;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 1) bcd_in = 16'h0100;
            if (i == 7) bcd_in = 16'h9999;
            want_done = (i == 5) || (i == 10);
            total_cnt++;
            if (done !== want_done)
                $display("[TB] FAIL b2b_done_%0d got %b want %b", i, done, want_done);
            else pass_cnt++;
            if (i == 5) begin
                total_cnt++;
                if (bin_out !== 14'd42) $display("[TB] FAIL b2b_first got %0d want 42", bin_out);
                else pass_cnt++;
            end
            if (i == 10) begin
                total_cnt++;
                if (bin_out !== 14'd100) $display("[TB] FAIL b2b_second got %0d want 100", bin_out);
                else pass_cnt++;
                start = 1'b0;
            end
        end
        // Extra start pulse while busy is ignored, not queued.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h0055;
        @(negedge clk);
        start = 1'b0;
        for (int i = 2; i <= 10; i++) begin
            @(negedge clk);
            if (i == 2) begin
                start  = 1'b1;
                bcd_in = 16'h0999;
            end else begin
                start = 1'b0;
            end
            want_done = (i == 5);
            total_cnt++;
            if (done !== want_done)
                $display("[TB] FAIL busy_ignore_done_%0d got %b want %b", i, done, want_done);
            else pass_cnt++;
            if (i == 5) begin
                total_cnt++;
                if (bin_out !== 14'd55) $display("[TB] FAIL busy_ignore_bin got %0d want 55", bin_out);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic [13:0] res; logic e; logic b;
        logic saw_done;
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h5678;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || bin_out !== 14'd0)
            $display("[TB] FAIL abort_outputs got busy=%b done=%b err=%b bin=%0d want 0/0/0/0",
                     busy, done, err, bin_out);
        else pass_cnt++;
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        total_cnt++;
        if (saw_done !== 1'b0) $display("[TB] FAIL abort_no_done got %b want 0", saw_done);
        else pass_cnt++;
        run_conv(16'h0001, lat, res, e, b);
        total_cnt++;
        if (res !== 14'd1 || e !== 1'b0 || lat != 5)
            $display("[TB] FAIL abort_recover got bin=%0d err=%b lat=%0d want 1/0/5", res, e, lat);
        else pass_cnt++;
    endtask

    task automatic test_exhaustive();
        int lat; logic [13:0] res; logic e; logic b;
        logic [15:0] bcd;
        for (int v = 0; v < 10000; v++) begin
            bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            run_conv(bcd, lat, res, e, b);
            total_cnt++;
            if (res !== 14'(v) || e !== 1'b0 || lat != 5)
                $display("[TB] FAIL sweep_%0d got bin=%0d err=%b lat=%0d want %0d/0/5",
                         v, res, e, lat, v);
            else pass_cnt++;
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
    endtask

    task automatic test_three_digit();
        int lat;
        @(negedge clk);
        start3  = 1'b1;
        bcd_in3 = 12'h999;
        @(negedge clk);
        start3 = 1'b0;
        lat    = 1;
        while (!done3 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        total_cnt++;
        if (lat != 4) $display("[TB] FAIL d3_latency got %0d want 4", lat);
        else pass_cnt++;
        total_cnt++;
        if (bin_out3 !== 10'd999 || err3 !== 1'b0)
            $display("[TB] FAIL d3_999 got bin=%0d err=%b want 999/0", bin_out3, err3);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_error();
        test_back_to_back();
        test_reset_abort();
        test_three_digit();
        test_exhaustive();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
